// File: rtl/ball_dir_if.sv
// Bus between the pong rules controller and its environment.
// Ball/paddle samples and tick/start strobes in; direction bits and match status out.
interface ball_dir_if #(
    parameter int BIT_OF_WIDTH = 3,
    parameter int SCORE_W      = 4
);
    logic                    en;
    logic                    start;
    logic [BIT_OF_WIDTH-1:0] x_pos;
    logic [BIT_OF_WIDTH-1:0] y_pos;
    logic [BIT_OF_WIDTH-1:0] pad_l_y;
    logic [BIT_OF_WIDTH-1:0] pad_r_y;
    logic                    x_dir;
    logic                    y_dir;
    logic                    endgame;
    logic                    serve;
    logic [SCORE_W-1:0]      score_l;
    logic [SCORE_W-1:0]      score_r;
    logic                    winner;

    modport master (
        output en, start, x_pos, y_pos, pad_l_y, pad_r_y,
        input  x_dir, y_dir, endgame, serve, score_l, score_r, winner
    );

    modport slave (
        input  en, start, x_pos, y_pos, pad_l_y, pad_r_y,
        output x_dir, y_dir, endgame, serve, score_l, score_r, winner
    );
endinterface

// File: rtl/ball_dir_ctrl.sv
// Pong direction/rules controller: wall and paddle bounces, goals, scoring, serves, match over.
// Optional macro PADDLE_SPIN_EN: top/bottom paddle-row hits steer y_dir.
module ball_dir_ctrl #(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int PAD_LEN      = 3,
    parameter int SCORE_W      = 4,
    parameter int MAX_SCORE    = 5,
    parameter int HOLD_TICKS   = 4
) (
    input logic        clk,
    input logic        rst,
    ball_dir_if.slave  bus
);
    localparam int PW     = BIT_OF_WIDTH + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {IDLE, PLAY, POINT, OVER} state_t;

    state_t              state, state_nxt;
    logic                x_dir_q, y_dir_q, serve_q, winner_q, concede_l_q;
    logic [SCORE_W-1:0]  score_l_q, score_r_q, score_l_inc, score_r_inc;
    logic [HOLD_W-1:0]   hold_q;
    logic [PW-1:0]       y_ext, bot_l, bot_r;
    logic                hit_l, hit_r, bounce_l, bounce_r;
    logic                goal_l, goal_r, goal, match_pt, y_nxt;

    // Paddle span computed one bit wider and clipped so it never wraps past the last row.
    function automatic logic [PW-1:0] pad_bot(input logic [BIT_OF_WIDTH-1:0] top);
        logic [PW-1:0] b;
        b = {1'b0, top} + PW'(PAD_LEN - 1);
        return (b > PW'(WIDTH - 1)) ? PW'(WIDTH - 1) : b;
    endfunction

    assign y_ext    = {1'b0, bus.y_pos};
    assign bot_l    = pad_bot(bus.pad_l_y);
    assign bot_r    = pad_bot(bus.pad_r_y);
    assign hit_l    = ({1'b0, bus.pad_l_y} <= y_ext) && (y_ext <= bot_l);
    assign hit_r    = ({1'b0, bus.pad_r_y} <= y_ext) && (y_ext <= bot_r);
    assign bounce_l = x_dir_q && (bus.x_pos == BIT_OF_WIDTH'(1)) && hit_l;
    assign bounce_r = !x_dir_q && (bus.x_pos == BIT_OF_WIDTH'(WIDTH - 2)) && hit_r;
    assign goal_l   = (bus.x_pos == '0);
    assign goal_r   = (bus.x_pos == BIT_OF_WIDTH'(WIDTH - 1));
    assign goal     = goal_l || goal_r;

    assign score_l_inc = (score_l_q >= SCORE_W'(MAX_SCORE)) ? score_l_q : score_l_q + SCORE_W'(1);
    assign score_r_inc = (score_r_q >= SCORE_W'(MAX_SCORE)) ? score_r_q : score_r_q + SCORE_W'(1);
    assign match_pt    = goal_l ? (score_r_inc == SCORE_W'(MAX_SCORE))
                                : (score_l_inc == SCORE_W'(MAX_SCORE));

    always_comb begin
        y_nxt = y_dir_q;
        if (!y_dir_q && bus.y_pos == BIT_OF_WIDTH'(WIDTH - 1)) y_nxt = 1'b1;
        else if (y_dir_q && bus.y_pos == '0)                   y_nxt = 1'b0;
`ifdef PADDLE_SPIN_EN
        // Spin applies off the wall rows only; at rows 0 and WIDTH-1 the wall rule stands.
        if ((bounce_l || bounce_r) && bus.y_pos != '0 && bus.y_pos != BIT_OF_WIDTH'(WIDTH - 1)) begin
            if (bus.y_pos == (bounce_l ? bus.pad_l_y : bus.pad_r_y)) y_nxt = 1'b1;
            else if (y_ext == (bounce_l ? bot_l : bot_r))            y_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = PLAY;
            PLAY:    if (bus.en && goal) state_nxt = match_pt ? OVER : POINT;
            POINT:   if (bus.en && hold_q <= HOLD_W'(1)) state_nxt = PLAY;
            OVER:    if (bus.start) state_nxt = PLAY;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.x_dir   = x_dir_q;
        bus.y_dir   = y_dir_q;
        bus.endgame = (state != PLAY);
        bus.serve   = serve_q;
        bus.score_l = score_l_q;
        bus.score_r = score_r_q;
        bus.winner  = winner_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_dir_q     <= 1'b0;
            y_dir_q     <= 1'b0;
            serve_q     <= 1'b0;
            winner_q    <= 1'b0;
            concede_l_q <= 1'b0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            hold_q      <= '0;
        end else begin
            serve_q <= (state_nxt == PLAY) && (state != PLAY);
            case (state)
                IDLE, OVER: if (bus.start) begin
                    x_dir_q   <= 1'b0;
                    y_dir_q   <= 1'b0;
                    winner_q  <= 1'b0;
                    score_l_q <= '0;
                    score_r_q <= '0;
                    hold_q    <= '0;
                end
                PLAY: if (bus.en) begin
                    y_dir_q <= y_nxt;
                    if (goal) begin
                        if (goal_l) score_r_q <= score_r_inc;
                        else        score_l_q <= score_l_inc;
                        concede_l_q <= goal_l;
                        hold_q      <= match_pt ? '0 : HOLD_W'(HOLD_TICKS);
                        if (match_pt) winner_q <= goal_l;
                    end else if (bounce_l) begin
                        x_dir_q <= 1'b0;
                    end else if (bounce_r) begin
                        x_dir_q <= 1'b1;
                    end
                end
                POINT: if (bus.en) begin
                    if (hold_q != '0) hold_q <= hold_q - HOLD_W'(1);
                    // Serve heads toward whoever conceded; y alternates every serve.
                    if (hold_q <= HOLD_W'(1)) begin
                        x_dir_q <= concede_l_q;
                        y_dir_q <= ~y_dir_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ball_dir_ctrl.md
Name: ball_dir_ctrl

Overview:
- Direction and rules controller for the pong playfield.
- Samples the ball position from pos_ball and the two paddle positions on each game tick.
- Produces the x/y direction bits that pos_ball consumes, using pos_ball's encoding: 0 = increment, 1 = decrement.
- Owns the endgame flag, per-player scores, serve requests and match-over detection.

Parameters:
WIDTH, 8, playfield size in cells per axis; columns/rows 0..WIDTH-1
BIT_OF_WIDTH, 3, width of position buses
PAD_LEN, 3, paddle height in cells
SCORE_W, 4, score counter width
MAX_SCORE, 5, points needed to win the match
HOLD_TICKS, 4, en ticks the ball stays frozen after a point

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  game tick strobe, same signal that drives pos_ball en
start  in  1  start/restart request, level-sampled
x_pos  in  BIT_OF_WIDTH  ball column from pos_ball
y_pos  in  BIT_OF_WIDTH  ball row from pos_ball
pad_l_y  in  BIT_OF_WIDTH  top row of left paddle (column 0)
pad_r_y  in  BIT_OF_WIDTH  top row of right paddle (column WIDTH-1)
x_dir  out  1  to pos_ball x_in; 0 = moving right, 1 = moving left
y_dir  out  1  to pos_ball y_in; 0 = moving down, 1 = moving up
endgame  out  1  to pos_ball endgame; 1 freezes the ball
serve  out  1  one-clock pulse; top level drives pos_ball en low for one tick to recentre the ball
score_l  out  SCORE_W  left player score
score_r  out  SCORE_W  right player score
winner  out  1  valid in OVER; 0 = left won, 1 = right won

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, x_dir=0, y_dir=0, endgame=1, serve=0.
  - score_l=0, score_r=0, winner=0, hold counter=0.
- States: IDLE, PLAY, POINT, OVER.
- IDLE:
  - endgame=1.
  - start=1 → PLAY; endgame=0; serve pulses for 1 clk; x_dir=0, y_dir=0.
- PLAY: evaluate only on clocks where en=1. No change when en=0.
- Y walls:
  - y_dir=0 and y_pos==WIDTH-1 → y_dir=1.
  - y_dir=1 and y_pos==0 → y_dir=0.
- Paddle hit test:
  - Hit when pad_y <= y_pos <= pad_y+PAD_LEN-1.
  - Compute in BIT_OF_WIDTH+1 bits; the paddle span clips at WIDTH-1 and never wraps.
- Left paddle:
  - x_dir=1 and x_pos==1 and hit on pad_l_y → x_dir=0.
  - Miss → no change; the ball proceeds to column 0.
- Right paddle:
  - x_dir=0 and x_pos==WIDTH-2 and hit on pad_r_y → x_dir=1.
- X and Y updates are independent. A corner (wall plus paddle on the same tick) flips both bits on that tick.
- Goal, left side: x_pos==0 → score_r+1, endgame=1, state=POINT, hold counter=HOLD_TICKS.
- Goal, right side: x_pos==WIDTH-1 → score_l+1, endgame=1, state=POINT, hold counter=HOLD_TICKS.
- A goal takes priority over a bounce on the same tick. The y-wall rule still applies.
- POINT:
  - Hold counter decrements on each en.
  - If the incremented score == MAX_SCORE: enter OVER on POINT entry; winner is set; no hold.
  - Otherwise, counter reaching 0 → PLAY, endgame=0, serve pulse.
  - Serve direction: x_dir points toward the player who conceded (left conceded → x_dir=1). y_dir toggles on every serve.
- OVER:
  - endgame=1; scores are held.
  - start=1 → clear scores, winner=0, x_dir=0, y_dir=0 → PLAY with serve pulse.
- Scores saturate at MAX_SCORE and never wrap.
- start is ignored in PLAY and POINT.
- rst asserted mid-rally or mid-hold returns immediately to the reset values above.

Optional Feature:
- Macro: PADDLE_SPIN_EN.
- Defined: a paddle hit on the paddle's top row forces y_dir=1; a hit on its bottom row (pad_y+PAD_LEN-1) forces y_dir=0. This overrides the y-wall rule on that tick, except at rows 0 and WIDTH-1, where the wall rule wins. A middle-row hit leaves y_dir unchanged.
- Undefined: paddles affect x_dir only; y_dir changes only at walls and serves.

Test Plan:
- Reset then start=1: endgame drops to 0 one clk later, serve high exactly 1 clk, x_dir=0, y_dir=0, scores 0/0.
- PLAY, y_dir=0, y_pos=7, en=1 → y_dir=1. Then y_pos=0, en=1 → y_dir=0. x_dir unchanged throughout.
- x_dir=1, x_pos=1, y_pos=4, pad_l_y=3, en=1 → x_dir=0. Repeat with pad_l_y=5 → x_dir stays 1; next en with x_pos=0 → score_r=1, endgame=1; after 4 en ticks, serve pulse, endgame=0, x_dir=1, y_dir toggled.
- Corner: x_dir=0, y_dir=0, x_pos=6, y_pos=7, pad_r_y=5, en=1 → x_dir=1 and y_dir=1 on the same clk.
- Left scores 5 goals → state OVER, winner=0, endgame stays 1, score_l=5 held. start=1 → scores 0/0, serve pulse, PLAY.
- rst pulsed during POINT hold → all outputs at reset values; start is required to resume. With PADDLE_SPIN_EN defined: hit on pad_l_y=2 at y_pos=2 with y_dir=0 → y_dir=1.
